// File: rtl/bram_access_ctrl.sv
// rtl/bram_access_ctrl.sv - valid/ready request stream to single-port Bram initiator (optional macro BRAM_ACCESS_CTRL_WRITE_RESP_EN)
module bram_access_ctrl #(
  parameter int  P_WIDTH = 32,
  parameter int  P_SIZE  = 256,
  localparam int AW      = $clog2(P_SIZE),
  localparam int BW      = P_WIDTH / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iReqValid,
  output logic               oReqReady,
  input  logic               iReqWe,
  input  logic [AW-1:0]      iReqAddr,
  input  logic [BW-1:0]      iReqBe,
  input  logic [P_WIDTH-1:0] iReqData,
  output logic               oRespValid,
  input  logic               iRespReady,
  output logic [P_WIDTH-1:0] oRespData,
  output logic               oRamEn,
  output logic               oRamWe,
  output logic [AW-1:0]      oRamAddr,
  output logic [P_WIDTH-1:0] oRamData,
  input  logic [P_WIDTH-1:0] iRamData
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } state_t;

  // Where a finished write goes: a completion beat, or straight back to idle.
`ifdef BRAM_ACCESS_CTRL_WRITE_RESP_EN
  localparam state_t S_DONE = S_RESP;
`else
  localparam state_t S_DONE = S_IDLE;
`endif

  localparam logic [BW-1:0] BE_ALL = {BW{1'b1}};

  state_t               state_q, state_d;
  logic                 we_q;
  logic [AW-1:0]        addr_q;
  logic [BW-1:0]        be_q;
  logic [P_WIDTH-1:0]   data_q;
  logic [P_WIDTH-1:0]   resp_data_q;
  logic [P_WIDTH-1:0]   merged;
  logic                 accept;

  assign accept = iReqValid && (state_q == S_IDLE);

  // Byte merge of the write data over the word just read back from Bram.
  always_comb begin
    merged = iRamData;
    for (int b = 0; b < BW; b++) begin
      if (be_q[b]) merged[8*b +: 8] = data_q[8*b +: 8];
    end
  end

  // Next state and Bram strobes, decoded from the registered state only.
  always_comb begin
    state_d   = state_q;
    oReqReady = 1'b0;
    oRamEn    = 1'b0;
    oRamWe    = 1'b0;
    case (state_q)
      S_IDLE: begin
        oReqReady = 1'b1;
        if (iReqValid) begin
          if (!iReqWe)               state_d = S_RD;
          else if (iReqBe == BE_ALL) state_d = S_WR;
          else if (iReqBe == '0)     state_d = S_DONE;
          else                       state_d = S_RD;
        end
      end
      S_RD: begin
        oRamEn  = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        state_d = we_q ? S_WR : S_RESP;
      end
      S_WR: begin
        oRamEn  = 1'b1;
        oRamWe  = 1'b1;
        state_d = S_DONE;
      end
      S_RESP: begin
        if (iRespReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request latches, read-modify-write merge and response data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
    end else begin
      if (accept) begin
        we_q   <= iReqWe;
        addr_q <= iReqAddr;
        be_q   <= iReqBe;
        data_q <= iReqData;
`ifdef BRAM_ACCESS_CTRL_WRITE_RESP_EN
        if (iReqWe) resp_data_q <= '0;
`endif
      end
      if (state_q == S_RD_WAIT) begin
        if (we_q) data_q      <= merged;
        else      resp_data_q <= iRamData;
      end
    end
  end

  assign oRespValid = (state_q == S_RESP);
  assign oRespData  = resp_data_q;
  assign oRamAddr   = addr_q;
  assign oRamData   = data_q;

endmodule

// File: tb/tb_bram_access_ctrl.sv
// tb/tb_bram_access_ctrl.sv - table-driven and timing checks of bram_access_ctrl against a Bram model
module tb_bram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_data;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  bram_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .iReqValid(req_valid), .oReqReady(req_ready), .iReqWe(req_we),
    .iReqAddr(req_addr), .iReqBe(req_be), .iReqData(req_data),
    .oRespValid(resp_valid), .iRespReady(resp_ready), .oRespData(resp_data),
    .oRamEn(ram_en), .oRamWe(ram_we), .oRamAddr(ram_addr),
    .oRamData(ram_wdata), .iRamData(ram_rdata)
  );

  // Bram model: registered read (read-first), plus a bench preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        do_pre;
    logic [31:0] pre;
    logic [31:0] exp;
  } vec_t;

  vec_t vec [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drive one request; returns 1 ns after the accepting edge.
  task automatic accept(input logic we, input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_data = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) timeout("accept");
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic pop_check(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: unexpected response %h", name, resp_data);
    end else begin
      e = exp_q.pop_front();
      check(name, resp_data, e);
    end
  endtask

  task automatic wait_resp(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      timeout(name);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      pop_check(name);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) timeout(name);
  endtask

  initial begin
    int en_seen;
    vec[0] = '{1'b0, 8'd5,   4'h0,    32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vec[1] = '{1'b1, 8'd7,   4'hF,    32'h12345678, 1'b1, 32'h0,        32'h12345678};
    vec[2] = '{1'b0, 8'd7,   4'h0,    32'h0,        1'b0, 32'h0,        32'h12345678};
    vec[3] = '{1'b1, 8'd3,   4'b0101, 32'h11223344, 1'b1, 32'hAABBCCDD, 32'hAA22CC44};
    vec[4] = '{1'b1, 8'd9,   4'b1010, 32'h00000000, 1'b1, 32'hFFFFFFFF, 32'h00FF00FF};
    vec[5] = '{1'b0, 8'd3,   4'hF,    32'h0,        1'b0, 32'h0,        32'hAA22CC44};
    vec[6] = '{1'b1, 8'd10,  4'h0,    32'h0,        1'b1, 32'h55555555, 32'h55555555};
    vec[7] = '{1'b1, 8'd255, 4'b1000, 32'hA1B2C3D4, 1'b1, 32'h0,        32'hA1000000};
    vec[8] = '{1'b0, 8'd255, 4'h0,    32'h0,        1'b0, 32'h0,        32'hA1000000};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0;
    req_data = '0; resp_ready = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);

    for (int i = 0; i < 9; i++) begin
      if (vec[i].do_pre) preload(vec[i].addr, vec[i].pre);
      if (!vec[i].we) exp_q.push_back(vec[i].exp);
`ifdef BRAM_ACCESS_CTRL_WRITE_RESP_EN
      else exp_q.push_back(32'h0);
`endif
      accept(vec[i].we, vec[i].addr, vec[i].be, vec[i].wdata);
      if (!vec[i].we) begin
        wait_resp($sformatf("vec%0d_rdata", i));
      end else begin
`ifdef BRAM_ACCESS_CTRL_WRITE_RESP_EN
        wait_resp($sformatf("vec%0d_wresp", i));
`endif
        wait_ready($sformatf("vec%0d_ready", i));
        check($sformatf("vec%0d_mem", i), mem[vec[i].addr], vec[i].exp);
      end
    end

    // Read timing: en in cycle N..N+1, response from edge N+2.
    exp_q.push_back(32'hDEADBEEF);
    accept(1'b0, 8'd5, 4'h0, 32'h0);
    @(negedge clk);
    check("rd_en_n", ram_en, 1);
    check("rd_we_n", ram_we, 0);
    check("rd_addr_n", ram_addr, 5);
    check("rd_ready_n", req_ready, 0);
    @(negedge clk);
    check("rd_en_n1", ram_en, 0);
    check("rd_valid_n1", resp_valid, 0);
    @(negedge clk);
    check("rd_valid_n2", resp_valid, 1);
    pop_check("rd_data_n2");
    @(negedge clk);
    check("rd_valid_after", resp_valid, 0);
    check("rd_ready_after", req_ready, 1);

    // Full write timing: single en&we cycle, written at edge N+1.
`ifdef BRAM_ACCESS_CTRL_WRITE_RESP_EN
    exp_q.push_back(32'h0);
`endif
    accept(1'b1, 8'd20, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    check("fw_en_n", ram_en, 1);
    check("fw_we_n", ram_we, 1);
    check("fw_wdata_n", ram_wdata, 32'hCAFEF00D);
    @(negedge clk);
    check("fw_en_n1", ram_en, 0);
    check("fw_mem_n1", mem[20], 32'hCAFEF00D);
`ifdef BRAM_ACCESS_CTRL_WRITE_RESP_EN
    check("fw_resp_n1", resp_valid, 1);
    pop_check("fw_resp_data");
    @(posedge clk);
    #1;
`else
    check("fw_ready_n1", req_ready, 1);
    check("fw_no_resp", resp_valid, 0);
`endif

    // Partial write timing: read at N, merge at N+2, written at edge N+3.
    preload(8'd21, 32'h0);
`ifdef BRAM_ACCESS_CTRL_WRITE_RESP_EN
    exp_q.push_back(32'h0);
`endif
    accept(1'b1, 8'd21, 4'b0011, 32'h12345678);
    @(negedge clk);
    check("pw_en_n", ram_en, 1);
    check("pw_we_n", ram_we, 0);
    @(negedge clk);
    check("pw_en_n1", ram_en, 0);
    @(negedge clk);
    check("pw_we_n2", ram_we, 1);
    check("pw_wdata_n2", ram_wdata, 32'h00005678);
    check("pw_ready_n2", req_ready, 0);
    @(negedge clk);
    check("pw_mem_n3", mem[21], 32'h00005678);
`ifdef BRAM_ACCESS_CTRL_WRITE_RESP_EN
    check("pw_resp_n3", resp_valid, 1);
    pop_check("pw_resp_data");
    @(posedge clk);
    #1;
`else
    check("pw_ready_n3", req_ready, 1);
`endif

    // Backpressure: response held for 5 cycles with iRespReady low.
    resp_ready = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    accept(1'b0, 8'd5, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", c), resp_valid, 1);
      check($sformatf("bp_data_%0d", c), resp_data, 32'hDEADBEEF);
      check($sformatf("bp_ready_%0d", c), req_ready, 0);
      check($sformatf("bp_en_%0d", c), ram_en, 0);
    end
    pop_check("bp_pop");
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_after", resp_valid, 0);
    check("bp_ready_after", req_ready, 1);

    // be=0 write: no Bram activity at all.
    preload(8'd22, 32'h77777777);
`ifdef BRAM_ACCESS_CTRL_WRITE_RESP_EN
    exp_q.push_back(32'h0);
`endif
    accept(1'b1, 8'd22, 4'h0, 32'hFFFFFFFF);
    @(negedge clk);
    en_seen = int'(ram_en);
`ifdef BRAM_ACCESS_CTRL_WRITE_RESP_EN
    check("be0_resp_valid", resp_valid, 1);
    pop_check("be0_resp_data");
`else
    check("be0_ready_next", req_ready, 1);
    check("be0_no_resp", resp_valid, 0);
`endif
    repeat (3) begin
      @(negedge clk);
      en_seen += int'(ram_en);
    end
    check("be0_en_count", en_seen, 0);
    check("be0_mem", mem[22], 32'h77777777);

    // Reset in the middle of a read: no response ever appears.
    accept(1'b0, 8'd5, 4'h0, 32'h0);
    @(negedge clk);
    check("rr_en_before", ram_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rr_en_in_rst", ram_en, 0);
    check("rr_valid_in_rst", resp_valid, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rr_valid_%0d", c), resp_valid, 0);
      check($sformatf("rr_ready_%0d", c), req_ready, 1);
    end

    // Reset before the WR edge of a partial write leaves RAM unchanged.
    preload(8'd23, 32'hAABBCCDD);
    accept(1'b1, 8'd23, 4'b0001, 32'h000000FF);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rw_mem_kept", mem[23], 32'hAABBCCDD);
    check("rw_en_idle", ram_en, 0);

    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
